// File: rtl/ddhw_ch6_pkg.sv
// Shared definitions for the serial frame loader: state encoding, line levels
// and a sizing helper for the bit counter.
package ddhw_ch6_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_STOP = 2'd2;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_DATA = S_DATA,
      ST_STOP = S_STOP
   } state_t;

   // Counter must be able to hold WIDTH itself, hence the +1.
   function automatic int count_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_nibble_loader_bit_counter.sv
// Data-bit position counter: synchronous clear, count enable, terminal flag on
// the last data bit; wraps to zero when it advances past that bit.
module bit_counter #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          last
);

   assign last = (count == CW'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= last ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/serial_nibble_loader.sv
// Framed serial-to-parallel loader: start 0, WIDTH data bits LSB first, stop 1.
// Good frames update data with a one-cycle load; bad stop bits pulse frame_err.
module serial_nibble_loader
   import ddhw_ch6_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_en,
   input  logic             serial_in,
   input  logic             abort,
   output logic [WIDTH-1:0] data,
   output logic             load,
   output logic             busy,
   output logic             frame_err
);

   localparam int CW = count_width(WIDTH);

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    count;
   logic             count_last;
   logic [WIDTH-1:0] shift_reg;
   logic             count_clr;
   logic             count_en;
   logic             shift_en;
   logic             load_set;
   logic             err_set;

   bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_bit_counter (
      .clk   (clk),
      .reset (reset),
      .clear (count_clr),
      .en    (count_en),
      .count (count),
      .last  (count_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      count_clr  = 1'b0;
      count_en   = 1'b0;
      shift_en   = 1'b0;
      load_set   = 1'b0;
      err_set    = 1'b0;
      if (abort) begin
         // Abort wins over bit_en and over a valid stop bit on the same edge.
         state_next = ST_IDLE;
         count_clr  = 1'b1;
      end else if (bit_en) begin
         case (state)
            ST_IDLE: begin
               count_clr = 1'b1;
               if (serial_in == START_BIT) begin
                  state_next = ST_DATA;
               end
            end
            ST_DATA: begin
               shift_en = 1'b1;
               count_en = 1'b1;
               if (count_last) begin
                  state_next = ST_STOP;
               end
            end
            ST_STOP: begin
               state_next = ST_IDLE;
               if (serial_in == STOP_BIT) begin
                  load_set = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         data      <= '0;
         load      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         load      <= load_set;
         frame_err <= err_set;
         if (shift_en) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (count == CW'(i)) begin
                  shift_reg[i] <= serial_in;
               end
            end
         end
         if (load_set) begin
            data <= shift_reg;
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule
